inst_sram_axi_bridge: RTL and testbench

Read-only bridge between the instruction-side SRAM-like port driven by the IF stage (`inst_sram_*`) and an AXI3 master read channel (AR/R). It accepts up to `MAX_OUTSTANDING` in-order fetch requests, issues one single-beat AXI read per request, and returns data through `data_ok`. A `cancel` pulse from the exception/eret path discards the data of every request already accepted. The IF stage never sees stale instructions after a flush.

---
 rtl/inst_sram_axi_bridge_pkg.sv | 21 ++
 rtl/inst_sram_axi_bridge_req_counter.sv | 41 ++++
 rtl/inst_sram_axi_bridge.sv | 108 ++++++++++
 tb/tb_inst_sram_axi_bridge.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_axi_bridge_pkg.sv
// ============================================================================
// Module   : inst_sram_axi_bridge_pkg
// Brief    : Shared AXI constants and helpers for the instruction fetch bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_sram_axi_bridge_pkg;

    localparam int unsigned      c_axi_id_w       = 4;
    localparam logic [1:0]       c_axi_burst_incr = 2'b01;
    localparam logic [c_axi_id_w-1:0] c_inst_axi_id = 4'd0;

    // The SRAM-like size field is the byte count log2, which AXI encodes identically.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_sram_axi_bridge_req_counter.sv
// ============================================================================
// Module   : inst_sram_axi_bridge_req_counter
// Brief    : Outstanding-request and discard counters for the fetch bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_sram_axi_bridge_req_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       accept,
    input  logic       r_done,
    input  logic       cancel,
    output logic [1:0] out_cnt,
    output logic [1:0] discard_cnt
);

    logic [1:0] r_out_cnt;
    logic [1:0] r_discard_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_cnt     <= 2'd0;
            r_discard_cnt <= 2'd0;
        end else begin
            r_out_cnt <= r_out_cnt + {1'b0, accept} - {1'b0, r_done};
            // A request accepted in the cancel cycle is newer than the flush and is kept.
            if (cancel) begin
                r_discard_cnt <= r_out_cnt - {1'b0, r_done};
            end else if (r_done && (r_discard_cnt != 2'd0)) begin
                r_discard_cnt <= r_discard_cnt - 2'd1;
            end
        end
    end

    assign out_cnt     = r_out_cnt;
    assign discard_cnt = r_discard_cnt;

endmodule

`default_nettype wire

// File: rtl/inst_sram_axi_bridge.sv
// ============================================================================
// Module   : inst_sram_axi_bridge
// Brief    : Read-only bridge from the IF-stage SRAM-like port to AXI3 AR/R.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_sram_axi_bridge
    import inst_sram_axi_bridge_pkg::*;
#(
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [c_axi_id_w-1:0] AXI_ID          = c_inst_axi_id
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        cancel,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] c_max_out = MAX_OUTSTANDING[1:0];

    logic        r_ar_busy;
    logic [31:0] r_ar_addr;
    logic [1:0]  r_ar_size;

    logic [1:0]  w_out_cnt;
    logic [1:0]  w_discard_cnt;
    logic        w_accept;
    logic        w_r_done;

    // Write-side fields and AXI response metadata carry no information for fetches.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp};

    // resetn gating keeps the handshakes low while reset is held, not just after an edge.
    assign w_accept = inst_sram_req & resetn & ~r_ar_busy & (w_out_cnt < c_max_out);
    assign w_r_done = rvalid & rlast;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ar_busy <= 1'b0;
            r_ar_addr <= 32'd0;
            r_ar_size <= 2'd0;
        end else if (w_accept) begin
            r_ar_busy <= 1'b1;
            r_ar_addr <= inst_sram_addr;
            r_ar_size <= inst_sram_size;
        end else if (r_ar_busy && arready) begin
            r_ar_busy <= 1'b0;
        end
    end

    inst_sram_axi_bridge_req_counter u_req_counter (
        .clk         (clk),
        .resetn      (resetn),
        .accept      (w_accept),
        .r_done      (w_r_done),
        .cancel      (cancel),
        .out_cnt     (w_out_cnt),
        .discard_cnt (w_discard_cnt)
    );

    assign inst_sram_addr_ok = w_accept;
    assign inst_sram_data_ok = w_r_done & resetn & (w_discard_cnt == 2'd0) & ~cancel;
    assign inst_sram_rdata   = rdata;

    assign arid    = AXI_ID;
    assign araddr  = r_ar_addr;
    assign arlen   = 8'd0;
    assign arsize  = axi_size(r_ar_size);
    assign arburst = c_axi_burst_incr;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = r_ar_busy;
    assign rready  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_inst_sram_axi_bridge.sv
// ============================================================================
// Module   : tb_inst_sram_axi_bridge
// Brief    : Randomised bench for inst_sram_axi_bridge with a request-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_sram_axi_bridge;

    localparam int          MAX = 2;
    localparam logic [31:0] KEY = 32'h83dd0010;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr, cancel;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid, arcache, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    int vectors = 0;
    int miscompares = 0;
    int ar_pct = 100;
    int r_pct = 100;

    inst_sram_axi_bridge #(.MAX_OUTSTANDING(MAX), .AXI_ID(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .cancel(cancel),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // In-order slave: returns addr^KEY for every AR it has accepted.
    logic [31:0] slave_q[$];
    always @(posedge clk) begin : p_slave
        bit          hs_ar, hs_r;
        logic [31:0] a;
        hs_ar = arvalid && arready;
        hs_r  = rvalid && rlast;
        a     = araddr;
        #1;
        rid   = 4'($urandom);
        rresp = 2'($urandom);
        if (!resetn) begin
            slave_q.delete();
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'($urandom);
            rdata   = $urandom;
        end else begin
            if (hs_r && slave_q.size() > 0) void'(slave_q.pop_front());
            if (hs_ar) slave_q.push_back(a);
            arready = ($urandom_range(99) < ar_pct);
            if (slave_q.size() > 0 && $urandom_range(99) < r_pct) begin
                rvalid = 1'b1;
                rlast  = 1'b1;
                rdata  = slave_q[0] ^ KEY;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'($urandom);
                rdata  = $urandom;
            end
        end
    end

    // Model: a queue of accepted fetches, each remembering whether it was issued and flushed.
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        bit          issued;
        bit          discard;
    } req_t;
    req_t mq[$];

    always @(negedge clk) begin : p_model
        bit   e_arv, e_aok, rd, e_dok;
        req_t n;
        if (!resetn) begin
            mq.delete();
            check("reset_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
            check("reset_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
            check("reset_arvalid", {31'd0, arvalid}, 32'd0);
            check("reset_araddr", araddr, 32'd0);
            check("reset_rready", {31'd0, rready}, 32'd1);
        end else begin
            e_arv = (mq.size() > 0) && !mq[mq.size()-1].issued;
            e_aok = inst_sram_req && !e_arv && (mq.size() < MAX);
            rd    = rvalid && rlast;
            e_dok = rd && (mq.size() > 0) && !mq[0].discard && !cancel;
            check("addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, e_aok});
            check("arvalid", {31'd0, arvalid}, {31'd0, e_arv});
            check("data_ok", {31'd0, inst_sram_data_ok}, {31'd0, e_dok});
            check("rready", {31'd0, rready}, 32'd1);
            check("ar_consts", {arid, arlen, arburst, arlock, arcache, arprot, 9'd0}, {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 9'd0});
            if (e_arv) begin
                check("araddr", araddr, mq[mq.size()-1].addr);
                check("arsize", {29'd0, arsize}, {30'd0, mq[mq.size()-1].size});
            end
            if (e_dok) check("rdata", inst_sram_rdata, mq[0].addr ^ KEY);
            if (e_arv && arready) mq[mq.size()-1].issued = 1'b1;
            if (rd) begin
                if (mq.size() == 0) check("orphan_r_beat_queue_depth", 32'd0, 32'd1);
                else void'(mq.pop_front());
            end
            if (cancel) foreach (mq[i]) mq[i].discard = 1'b1;
            if (e_aok) begin
                n.addr = inst_sram_addr; n.size = inst_sram_size;
                n.issued = 1'b0; n.discard = 1'b0;
                mq.push_back(n);
            end
        end
    end

    task automatic drive_idle();
        inst_sram_req = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        ar_pct = 100; r_pct = 100;
        repeat (n) begin @(posedge clk); #1; drive_idle(); end
    endtask

    // Holds a request until accepted (bounded), then drops it on the next cycle.
    task automatic fetch_req(input logic [31:0] a);
        bit got = 1'b0;
        @(posedge clk); #1;
        inst_sram_req = 1'b1; inst_sram_addr = a; inst_sram_size = 2'd2; cancel = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("fetch_accepted", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        inst_sram_req = 1'b0;
    endtask

    task automatic run_random(input int n, input int arp, input int rp);
        ar_pct = arp; r_pct = rp;
        repeat (n) begin
            @(posedge clk); #1;
            inst_sram_req   = ($urandom_range(99) < 60);
            inst_sram_addr  = $urandom & 32'hffff_fffc;
            inst_sram_size  = 2'($urandom_range(2));
            cancel          = ($urandom_range(99) < 8);
            inst_sram_wr    = 1'($urandom);
            inst_sram_wstrb = 4'($urandom);
            inst_sram_wdata = $urandom;
        end
        drive_idle();
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int          n_ok;
        logic [31:0] last;
        bit          got;
        resetn = 1'b0;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1000; inst_sram_size = 2'd2;
        inst_sram_wr = 1'b0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0; cancel = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rid = 4'd0; rresp = 2'd0;
        repeat (3) @(posedge clk);
        #1; resetn = 1'b1; drive_idle();
        idle(2);

        // Single fetch with a zero-wait slave.
        @(posedge clk); #1;
        inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00000; inst_sram_size = 2'd2;
        @(negedge clk); check("single_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        @(posedge clk); #1; inst_sram_req = 1'b0;
        @(negedge clk);
        check("single_arvalid", {31'd0, arvalid}, 32'd1);
        check("single_araddr", araddr, 32'hbfc00000);
        check("single_arsize", {29'd0, arsize}, 32'd2);
        @(negedge clk);
        check("single_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        check("single_rdata", inst_sram_rdata, 32'h3c1d0010);
        idle(4);

        // AR backpressure: address must hold and a second request must wait.
        ar_pct = 0;
        fetch_req(32'hbfc00010);
        inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00020;
        repeat (5) begin
            @(negedge clk);
            check("bp_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
            check("bp_araddr", araddr, 32'hbfc00010);
        end
        ar_pct = 100;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) got = 1'b1;
        end
        check("bp_resume", {31'd0, got}, 32'd1);
        @(posedge clk); #1; drive_idle();
        idle(6);

        // Outstanding limit: third request blocked until R traffic resumes.
        r_pct = 0;
        fetch_req(32'hbfc00100);
        fetch_req(32'hbfc00200);
        inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00300;
        repeat (4) begin
            @(negedge clk);
            check("full_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        end
        @(posedge clk); #1; r_pct = 100;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) got = 1'b1;
        end
        check("full_resume", {31'd0, got}, 32'd1);
        @(posedge clk); #1; drive_idle();
        idle(8);

        // Cancel with two outstanding; only the post-flush fetch may return.
        r_pct = 0;
        fetch_req(32'hbfc00100);
        fetch_req(32'hbfc00200);
        cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0; r_pct = 100;
        n_ok = 0; last = 32'd0;
        fork
            fetch_req(32'hbfc00380);
            repeat (25) begin
                @(negedge clk);
                if (inst_sram_data_ok) begin n_ok++; last = inst_sram_rdata; end
            end
        join
        check("cancel_data_ok_count", n_ok, 32'd1);
        check("cancel_kept_rdata", last, 32'h3c1d0390);
        idle(4);

        run_random(600, 100, 100);
        run_random(600, 40, 30);
        run_random(600, 70, 10);

        // Asynchronous reset while an AR is pending.
        ar_pct = 0; r_pct = 50;
        fetch_req(32'hbfc00400);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (arvalid) got = 1'b1;
        end
        check("rst_arvalid_seen", {31'd0, got}, 32'd1);
        #2;
        resetn = 1'b0; inst_sram_req = 1'b1;
        #1;
        check("async_rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("async_rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        check("async_rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1;
        run_random(600, 80, 60);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
